dot_product_seq_ctrl: RTL and testbench

Sequencer that computes a signed dot product of two vectors held in two 1-cycle-latency ROM/BRAM ports. It streams one element pair per cycle into an external 2-stage pipelined signed 32x32->32 multiplier (clock-enabled, registered output) and accumulates the products. It sits between the top-level start/done handshake and the multiplier/memory datapath, and owns all addressing, multiplier clock-enable and accumulation.

---
 rtl/dot_product_seq_ctrl_if.sv | 31 +++
 rtl/dot_product_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_dot_product_seq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_seq_ctrl_if.sv
// Handshake, memory-read and multiplier bus of the dot-product sequencer.
// The slave modport is the sequencer side; master is the surrounding system.
interface dot_product_seq_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned LEN_WIDTH  = 5
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  len;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ce;
    logic [DATA_WIDTH-1:0] mem_a_q;
    logic [DATA_WIDTH-1:0] mem_b_q;
    logic [DATA_WIDTH-1:0] mul_din0;
    logic [DATA_WIDTH-1:0] mul_din1;
    logic                  mul_ce;
    logic [DATA_WIDTH-1:0] mul_dout;

    modport slave (
        input  start, len, mem_a_q, mem_b_q, mul_dout,
        output busy, done, result, mem_addr, mem_ce, mul_din0, mul_din1, mul_ce
    );

    modport master (
        output start, len, mem_a_q, mem_b_q, mul_dout,
        input  busy, done, result, mem_addr, mem_ce, mul_din0, mul_din1, mul_ce
    );
endinterface

// File: rtl/dot_product_seq_ctrl.sv
// Signed dot-product sequencer: streams element pairs from two 1-cycle
// memories into an external 2-stage multiplier and accumulates the products
// modulo 2**DATA_WIDTH.
module dot_product_seq_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned LEN_WIDTH  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    dot_product_seq_ctrl_if.slave  bus
);
    localparam int unsigned MAX_LEN = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [ADDR_WIDTH-1:0] r_last;
    logic [ADDR_WIDTH-1:0] w_last_nxt;
    logic                  r_mem_ce;
    logic                  w_mem_ce_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_v1;
    logic                  r_v2;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] w_acc_sum;
    logic [DATA_WIDTH-1:0] w_acc_nxt;
    logic                  w_acc_clr;
    logic [DATA_WIDTH-1:0] r_result;
    logic [DATA_WIDTH-1:0] w_result_nxt;
    logic [LEN_WIDTH-1:0]  w_len_clamped;

    // Lengths beyond the memory depth are clamped to the full depth.
    assign w_len_clamped = (bus.len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : bus.len;

    // Accumulator folds in the product whenever the product stage is valid.
    assign w_acc_sum = r_v2 ? (r_acc + bus.mul_dout) : r_acc;
    assign w_acc_nxt = w_acc_clr ? '0 : w_acc_sum;

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_last_nxt   = r_last;
        w_mem_ce_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;
        w_acc_clr    = 1'b0;
        w_busy_nxt   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_acc_clr  = 1'b1;
                    w_addr_nxt = '0;
                    w_last_nxt = ADDR_WIDTH'(w_len_clamped - LEN_WIDTH'(1));
                    if (w_len_clamped != '0) begin
                        w_state_nxt  = S_ISSUE;
                        w_mem_ce_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = S_DONE;
                        w_done_nxt   = 1'b1;
                        w_result_nxt = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (r_addr == r_last) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_addr_nxt   = r_addr + ADDR_WIDTH'(1);
                    w_mem_ce_nxt = 1'b1;
                end
            end
            S_DRAIN: begin
                // With read-data valid gone, the last product is in flight this
                // cycle; capture the sum including it as the result.
                if (!r_v1) begin
                    w_state_nxt  = S_DONE;
                    w_done_nxt   = 1'b1;
                    w_result_nxt = w_acc_sum;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_DRAIN);
    end

    // State, output and pipeline-valid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_last   <= '0;
            r_mem_ce <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_last   <= w_last_nxt;
            r_mem_ce <= w_mem_ce_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_v1     <= r_mem_ce;
            r_v2     <= r_v1;
            r_acc    <= w_acc_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.mem_addr = r_addr;
    assign bus.mem_ce   = r_mem_ce;
    assign bus.mul_ce   = r_v1;
    assign bus.mul_din0 = bus.mem_a_q;
    assign bus.mul_din1 = bus.mem_b_q;
endmodule

// File: tb/tb_dot_product_seq_ctrl.sv
// Directed bench for dot_product_seq_ctrl with behavioural memory and
// 2-stage multiplier models around it.
module tb_dot_product_seq_ctrl;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned LW = 5;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dot_product_seq_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    dot_product_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];

    // 1-cycle-latency read ports
    always @(posedge clk) begin
        if (reset) begin
            bus.mem_a_q <= '0;
            bus.mem_b_q <= '0;
        end else if (bus.mem_ce) begin
            bus.mem_a_q <= mem_a[bus.mem_addr];
            bus.mem_b_q <= mem_b[bus.mem_addr];
        end
    end

    // Clock-enabled multiplier with registered, truncated product
    always @(posedge clk) begin
        if (reset)
            bus.mul_dout <= '0;
        else if (bus.mul_ce)
            bus.mul_dout <= bus.mul_din0 * bus.mul_din1;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [DW-1:0] va, input logic [DW-1:0] vb);
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = va;
            mem_b[i] = vb;
        end
    endtask

    int          j_done;
    int          j_ce;
    int          j_mul;
    int          j_busy;
    int          j_maxaddr;
    logic [31:0] j_res;

    // Start a job at cycle 0 and observe it until done (bounded).
    task automatic run_job(input int n, input bit hold);
        j_done = -1; j_ce = 0; j_mul = 0; j_busy = 0; j_maxaddr = -1; j_res = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = LW'(n);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (!hold) bus.start = 1'b0;
            if (bus.mem_ce) begin
                j_ce++;
                if (int'(bus.mem_addr) > j_maxaddr) j_maxaddr = int'(bus.mem_addr);
            end
            if (bus.mul_ce) j_mul++;
            if (bus.busy)   j_busy++;
            if (bus.done) begin
                j_done = k;
                j_res  = bus.result;
                break;
            end
        end
    endtask

    int          k2;
    int          stale;
    int          spurious;
    logic [31:0] res2;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.len   = '0;
        fill('0, '0);
        repeat (3) @(negedge clk);
        check_eq("rst_busy",   32'(bus.busy),     32'd0);
        check_eq("rst_done",   32'(bus.done),     32'd0);
        check_eq("rst_result", bus.result,        32'd0);
        check_eq("rst_addr",   32'(bus.mem_addr), 32'd0);
        check_eq("rst_mem_ce", 32'(bus.mem_ce),   32'd0);
        check_eq("rst_mul_ce", 32'(bus.mul_ce),   32'd0);
        reset = 1'b0;

        // Basic
        fill('0, '0);
        mem_a[0] = 32'd1; mem_a[1] = 32'd2; mem_a[2] = 32'd3; mem_a[3] = 32'd4;
        mem_b[0] = 32'd5; mem_b[1] = 32'd6; mem_b[2] = 32'd7; mem_b[3] = 32'd8;
        run_job(4, 1'b0);
        check_eq("basic_done_cyc", 32'(j_done),    32'd7);
        check_eq("basic_result",   j_res,          32'd70);
        check_eq("basic_ce_cnt",   32'(j_ce),      32'd4);
        check_eq("basic_max_addr", 32'(j_maxaddr), 32'd3);
        check_eq("basic_busy_cnt", 32'(j_busy),    32'd6);
        check_eq("basic_mul_cnt",  32'(j_mul),     32'd4);

        // Signed
        mem_a[0] = -32'sd3; mem_a[1] = 32'sd7;
        mem_b[0] = 32'sd4;  mem_b[1] = -32'sd2;
        run_job(2, 1'b0);
        check_eq("signed_done_cyc", 32'(j_done), 32'd5);
        check_eq("signed_result",   j_res,       32'hFFFF_FFE6);

        // Modular wrap of truncated products
        mem_a[0] = 32'h0001_0000; mem_a[1] = 32'h0001_0000; mem_a[2] = 32'd3;
        mem_b[0] = 32'h0001_0000; mem_b[1] = 32'h0001_0000; mem_b[2] = 32'd5;
        run_job(3, 1'b0);
        check_eq("wrap_done_cyc", 32'(j_done), 32'd6);
        check_eq("wrap_result",   j_res,       32'd15);

        // Zero length
        run_job(0, 1'b0);
        check_eq("len0_done_cyc", 32'(j_done), 32'd1);
        check_eq("len0_result",   j_res,       32'd0);
        check_eq("len0_ce_cnt",   32'(j_ce),   32'd0);
        check_eq("len0_mul_cnt",  32'(j_mul),  32'd0);
        check_eq("len0_busy_cnt", 32'(j_busy), 32'd0);

        // Full depth
        fill(32'd1, 32'd1);
        run_job(16, 1'b0);
        check_eq("len16_done_cyc", 32'(j_done),    32'd19);
        check_eq("len16_result",   j_res,          32'd16);
        check_eq("len16_ce_cnt",   32'(j_ce),      32'd16);
        check_eq("len16_max_addr", 32'(j_maxaddr), 32'd15);

        // Over-length clamps to full depth
        run_job(20, 1'b0);
        check_eq("clamp_done_cyc", 32'(j_done), 32'd19);
        check_eq("clamp_result",   j_res,       32'd16);
        check_eq("clamp_ce_cnt",   32'(j_ce),   32'd16);

        // Back-to-back with start held; second job reads changed data
        fill('0, '0);
        mem_a[0] = 32'd2; mem_a[1] = 32'd2;
        mem_b[0] = 32'd3; mem_b[1] = 32'd3;
        run_job(2, 1'b1);
        check_eq("b2b_done1_cyc", 32'(j_done), 32'd5);
        check_eq("b2b_result1",   j_res,       32'd12);
        mem_a[0] = 32'd1; mem_a[1] = 32'd1;
        k2 = -1; stale = 0; res2 = '0;
        for (int k = 6; k <= 40; k++) begin
            @(negedge clk);
            if (k == 8) bus.len = LW'(5);
            if (bus.done) begin
                k2   = k;
                res2 = bus.result;
                break;
            end
            if (bus.result !== 32'd12) stale++;
        end
        bus.start = 1'b0;
        check_eq("b2b_done2_cyc",   32'(k2),    32'd11);
        check_eq("b2b_result2",     res2,       32'd6);
        check_eq("b2b_result_hold", 32'(stale), 32'd0);

        // Reset mid-run
        fill(32'd1, 32'd1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = LW'(8);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 4) reset = 1'b1;
        end
        @(negedge clk);
        check_eq("abort_busy",   32'(bus.busy),     32'd0);
        check_eq("abort_done",   32'(bus.done),     32'd0);
        check_eq("abort_result", bus.result,        32'd0);
        check_eq("abort_addr",   32'(bus.mem_addr), 32'd0);
        check_eq("abort_mem_ce", 32'(bus.mem_ce),   32'd0);
        check_eq("abort_mul_ce", 32'(bus.mul_ce),   32'd0);
        reset = 1'b0;
        spurious = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done || bus.mem_ce || bus.busy) spurious++;
        end
        check_eq("abort_quiet", 32'(spurious), 32'd0);

        mem_a[0] = 32'd1; mem_a[1] = 32'd2; mem_a[2] = 32'd3;
        run_job(3, 1'b0);
        check_eq("fresh_done_cyc", 32'(j_done), 32'd6);
        check_eq("fresh_result",   j_res,       32'd6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
